dcache_stall_ctrl: RTL
======================

Name: dcache_stall_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Issues the `stall_i` consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It asserts stall while a MEM-stage load or store misses, and releases it on the cycle the access hits.
- Owns the tag/valid/dirty arrays and the line data storage.
- Talks to the off-chip data memory model over a 256-bit line interface using an enable/ack handshake.

Parameters:
- NUM_SETS, 16, number of cache lines; power of two; index width IDX_W = log2(NUM_SETS).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width fixed at 5.
- TAG_W, 32-5-IDX_W (23 at defaults), tag field width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_MemRead_i  in  1  load request in the MEM stage.
- cpu_MemWrite_i  in  1  store request in the MEM stage.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word accesses only).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid while a load hits.
- cpu_stall_o  out  1  pipeline stall to every pipeline register's `stall_i`.
- mem_data_i  in  256  refill line from memory.
- mem_ack_i  in  1  one-cycle pulse: memory finished the current transaction.
- mem_addr_o  out  32  line-aligned memory address (bits [4:0] = 0).
- mem_data_o  out  256  writeback line.
- mem_enable_o  out  1  one-cycle request pulse.
- mem_write_o  out  1  1 = writeback, 0 = refill; qualified by `mem_enable_o`.

Behaviour:
- Address split:
  - tag = addr[31:5+IDX_W]
  - index = addr[5+IDX_W-1:5]
  - word = addr[4:2]
- req = cpu_MemRead_i | cpu_MemWrite_i. If both are set, the access is treated as a store.
- hit = req & valid[index] & (tag_array[index] == tag).
- Reset:
  - state = IDLE; all valid and dirty bits cleared; issued flag cleared.
  - `mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o`, `cpu_data_o` = 0.
  - `cpu_stall_o` = 0 on the cycle after reset, since state is IDLE and no request is pending.
  - Line data contents are don't-care.
- `cpu_stall_o` = req & ~(state==IDLE & hit). It is combinational, so it rises in the same cycle a missing request appears.
- `cpu_data_o` = the selected word of line[index] when state==IDLE and the access is a load hit; 0 otherwise.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE, store hit: at the clock edge, write `cpu_data_i` into word[word] of line[index] and set dirty[index]=1. Zero-latency, no stall.
  - IDLE, load hit: no state change.
  - IDLE, miss with valid & dirty victim: go to WRITEBACK.
  - IDLE, any other miss: go to REFILL.
  - WRITEBACK:
    - On the first cycle in the state, pulse `mem_enable_o`=1 and `mem_write_o`=1.
    - `mem_addr_o` = {victim tag, index, 5'b0}; `mem_data_o` = line[index].
    - Hold addr/data stable until the ack.
    - On `mem_ack_i`, clear dirty[index] and go to REFILL.
  - REFILL:
    - On the first cycle in the state, pulse `mem_enable_o`=1 and `mem_write_o`=0.
    - `mem_addr_o` = {tag, index, 5'b0}.
    - On `mem_ack_i`: line[index] = `mem_data_i`, tag_array[index] = tag, valid=1, dirty=0; go to IDLE.
    - The next cycle re-evaluates as a hit. A store then writes and sets dirty through the normal store-hit path.
- `mem_enable_o` is a single-cycle pulse per transaction, generated from an issued flag that is cleared on every state change. It is never re-asserted while awaiting an ack.
- Miss penalty:
  - clean miss: refill latency + 1 cycle
  - dirty miss: writeback latency + refill latency + 1 cycle
- `mem_ack_i` in IDLE is ignored.
- The request and address must stay stable while `cpu_stall_o`=1. The pipeline guarantees this because every pipeline register is frozen by the same stall.
- If req drops while in WRITEBACK/REFILL (flush), the transaction still completes and the line is still installed.
- Reset mid-transaction returns to IDLE and clears all valid bits. A late `mem_ack_i` is then ignored; the memory model is reset by the same `rst_i`.
- Index wrap: two addresses differing only in tag map to the same set and evict each other.

Test Plan:
- Cold load at 0x0000_0040 after reset, memory latency 10:
  - `cpu_stall_o`=1 immediately.
  - One REFILL pulse with `mem_addr_o`=0x40, `mem_write_o`=0.
  - Stall drops the cycle after ack; `cpu_data_o` = word 0 of the returned line.
- Store hit to 0x44 with 0xDEADBEEF:
  - No stall, no memory traffic.
  - A following load of 0x44 returns 0xDEADBEEF with no stall.
- Dirty eviction, store to 0x44 then load 0x244 (same index, NUM_SETS=16):
  - WRITEBACK pulse with `mem_addr_o`=0x40 and `mem_data_o` word1=0xDEADBEEF.
  - Then REFILL pulse with `mem_addr_o`=0x240; stall spans both transactions.
- Store miss at 0x80:
  - REFILL of 0x80, then the store is written; dirty=1.
  - A later eviction of index 4 produces a writeback containing the store data.
- Reset asserted during REFILL (before ack):
  - Next cycle state=IDLE, `mem_enable_o`=0, `cpu_stall_o`=0 with no request pending.
  - A late ack is ignored; a reload of the same address misses again.
- `mem_enable_o` pulse check with latency 20:
  - Exactly one enable-high cycle per transaction; `mem_addr_o` stable until ack.

Source files
------------

// File: rtl/dcache_stall_ctrl.sv
// rtl/dcache_stall_ctrl.sv - direct-mapped write-back data cache controller with pipeline stall
module dcache_stall_ctrl #(
   parameter int NUM_SETS  = 16,
   parameter int LINE_BITS = 256,
   parameter int IDX_W     = $clog2(NUM_SETS),
   parameter int TAG_W     = 32 - 5 - IDX_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_MemRead_i,
   input  logic                 cpu_MemWrite_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t                 state;
   logic                   issued;
   logic [NUM_SETS-1:0]    valid;
   logic [NUM_SETS-1:0]    dirty;
   logic [TAG_W-1:0]       tag_array [NUM_SETS];
   logic [LINE_BITS-1:0]   line_data [NUM_SETS];
   logic [TAG_W-1:0]       miss_tag;
   logic [IDX_W-1:0]       miss_idx;

   logic [TAG_W-1:0]       tag;
   logic [IDX_W-1:0]       idx;
   logic [2:0]             word;
   logic                   req;
   logic                   hit;
   logic                   idle_hit;
   logic                   store_hit_we;
   logic                   refill_we;
   logic [LINE_BITS-1:0]   cur_line;
   logic                   unused_addr_bits;

   assign tag              = cpu_addr_i[31:5+IDX_W];
   assign idx              = cpu_addr_i[5+IDX_W-1:5];
   assign word             = cpu_addr_i[4:2];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign req      = cpu_MemRead_i | cpu_MemWrite_i;
   assign hit      = req & valid[idx] & (tag_array[idx] == tag);
   assign idle_hit = (state == IDLE) & hit;
   assign cur_line = line_data[idx];

   assign cpu_stall_o  = req & ~idle_hit;
   assign cpu_data_o   = (idle_hit & ~cpu_MemWrite_i) ? cur_line[{word, 5'b00000} +: 32] : 32'h0;

   // One request pulse per transaction: issued is set after the first cycle in a state
   assign mem_enable_o = (state != IDLE) & ~issued;
   assign mem_write_o  = (state == WRITEBACK) & ~issued;

   assign store_hit_we = ~rst_i & idle_hit & cpu_MemWrite_i;
   assign refill_we    = ~rst_i & (state == REFILL) & mem_ack_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         issued     <= 1'b0;
         valid      <= '0;
         dirty      <= '0;
         miss_tag   <= '0;
         miss_idx   <= '0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               issued <= 1'b0;
               if (hit && cpu_MemWrite_i) begin
                  dirty[idx] <= 1'b1;
               end else if (req && !hit) begin
                  // Latch the miss so a flush of the request cannot corrupt the fill
                  miss_tag <= tag;
                  miss_idx <= idx;
                  if (valid[idx] && dirty[idx]) begin
                     state      <= WRITEBACK;
                     mem_addr_o <= {tag_array[idx], idx, 5'b00000};
                     mem_data_o <= line_data[idx];
                  end else begin
                     state      <= REFILL;
                     mem_addr_o <= {tag, idx, 5'b00000};
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  dirty[miss_idx] <= 1'b0;
                  state           <= REFILL;
                  issued          <= 1'b0;
                  mem_addr_o      <= {miss_tag, miss_idx, 5'b00000};
               end else begin
                  issued <= 1'b1;
               end
            end
            REFILL: begin
               if (mem_ack_i) begin
                  valid[miss_idx] <= 1'b1;
                  dirty[miss_idx] <= 1'b0;
                  state           <= IDLE;
                  issued          <= 1'b0;
               end else begin
                  issued <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               issued <= 1'b0;
            end
         endcase
      end
   end

   // Line data and tags carry no reset; valid bits qualify them
   always_ff @(posedge clk_i) begin
      if (store_hit_we) begin
         line_data[idx][{word, 5'b00000} +: 32] <= cpu_data_i;
      end
      if (refill_we) begin
         line_data[miss_idx] <= mem_data_i;
         tag_array[miss_idx] <= miss_tag;
      end
   end

endmodule
